md_ctrl: RTL
============

Name: md_ctrl

Overview:
- Sequences the multi-cycle multiply/divide unit that owns the HI/LO registers.
- Accepts an operation from the E stage, runs a latency counter, then commits the result to HI/LO.
- Generates the stall request for dependent HI/LO instructions in D.
- Its HI/LO outputs feed the E-stage forwarding mux and the hilo pipeline field carried through M and W.

Parameters:
- MUL_LAT, 5, busy cycles for MULT/MULTU (legal range 1..15)
- DIV_LAT, 10, busy cycles for DIV/DIVU (legal range 1..15)

Ports:
- clk  in  1  system clock, rising edge
- reset  in  1  asynchronous, active-high
- start  in  1  E stage holds a valid md-class instruction this cycle
- op  in  3  operation code: MULT=0, MULTU=1, DIV=2, DIVU=3, MTHI=4, MTLO=5; 6 and 7 are no-ops
- src_a  in  32  rs operand, forwarded value
- src_b  in  32  rt operand, forwarded value
- use_md_D  in  1  D-stage instruction is mult/multu/div/divu/mfhi/mflo/mthi/mtlo
- cancel  in  1  abort the in-flight operation; present only with MD_CANCEL_EN
- busy  out  1  multi-cycle operation in progress
- stall  out  1  stall request to hazard unit, equals use_md_D & (start | busy), combinational
- done  out  1  one-cycle pulse, first cycle new HI/LO are visible after MUL/DIV
- hi  out  32  HI register
- lo  out  32  LO register

Behaviour:
- Reset (asynchronous, active-high): state=IDLE, count=0, hi=0, lo=0, pending regs=0, busy=0, done=0. A reset mid-operation discards the pending result.
- States:
  - IDLE: no operation in flight.
  - RUN: counting down an accepted MUL/DIV.
- IDLE, start & op in {0,1,2,3}:
  - Capture the result into pending_hi/pending_lo at this edge.
  - Load count = MUL_LAT-1 or DIV_LAT-1 (per op).
  - Go to RUN; busy=1 from the next cycle.
- IDLE, start & op=4: hi<=src_a at this edge. lo unchanged, busy stays 0, no done pulse.
- IDLE, start & op=5: lo<=src_a at this edge. Same rules as op=4.
- RUN: count decrements each edge. At the edge where count==0:
  - hi<=pending_hi, lo<=pending_lo.
  - state<=IDLE, busy<=0, done<=1 for one cycle.
- Total busy duration is exactly MUL_LAT or DIV_LAT cycles.
- start while RUN is ignored, including MTHI/MTLO. Correct programs cannot produce this because stall holds them in D; no assertion is raised.
- start with op 6 or 7: no effect.
- Result arithmetic:
  - MULT: 64-bit signed product {hi,lo}=a*b.
  - MULTU: 64-bit unsigned product {hi,lo}=a*b.
  - DIV: lo=quotient, hi=remainder; quotient truncates toward zero; remainder takes the sign of the dividend.
  - DIVU: same layout, unsigned.
  - DIV overflow 0x80000000/0xFFFFFFFF: lo=0x80000000, hi=0.
  - Divide by zero (DIV or DIVU): the op still runs the full DIV_LAT, but HI/LO are left unchanged at commit. done still pulses.
- hi/lo are register outputs only; no combinational path from inputs.
- done and a new start in the same cycle are legal: the new op is accepted, because the state is already IDLE.

Optional Feature:
- MD_CANCEL_EN defined:
  - The cancel port exists.
  - cancel=1 in RUN: at the next edge go to IDLE, busy=0, no commit, no done; HI/LO keep their old values.
  - cancel=1 in IDLE: suppresses a same-cycle start, including MTHI/MTLO.
  - cancel has priority over count==0 commit.
  - Used for exception flush (P7).
- MD_CANCEL_EN not defined: the cancel port is absent and every accepted op always commits.

Decomposition:
- Shared package/header md_pkg holds:
  - op encodings MD_MULT..MD_MTLO
  - state encodings ST_IDLE, ST_RUN
  - the 4-bit count width constant
- One sub-module, md_alu: combinational 64-bit result for op/src_a/src_b, including the signed/unsigned and divide-by-zero/overflow rules, plus a div-by-zero flag.
- md_ctrl instantiates md_alu and holds the FSM, counter and HI/LO registers.

Test Plan:
- MULT a=0xFFFFFFFE (-2), b=3 -> busy high 5 cycles; then hi=0xFFFFFFFF, lo=0xFFFFFFFA; done pulses once.
- DIVU a=100, b=7 -> busy 10 cycles; then lo=14, hi=2. DIV a=-7 (0xFFFFFFF9), b=2 -> lo=0xFFFFFFFD, hi=0xFFFFFFFF.
- use_md_D=1 on the start cycle and through busy -> stall=1 in every one of those cycles, 0 on the cycle after busy falls. use_md_D=0 -> stall=0 throughout.
- MTHI a=0x12345678 in IDLE -> hi=0x12345678 next cycle, busy never asserts. DIV b=0 -> after 10 cycles hi/lo unchanged, done pulses.
- Assert reset at RUN cycle 3 of a MULT -> immediately busy=0, hi=lo=0, no done. MTLO issued during RUN -> lo unchanged.
- With MD_CANCEL_EN: cancel at RUN cycle 2 of DIV -> busy=0 next cycle, HI/LO keep prior values, no done.

Source files
------------

// File: rtl/md_pkg.sv
`default_nettype none
// ============================================================================
//  Module   : md_pkg
//  Purpose  : Shared encodings for the multiply/divide controller: op codes,
//             FSM state type and latency-counter width.
//  Revision : 1.0  initial release
// ============================================================================
package md_pkg;

  // Latency counter width; covers latencies 1..15
  localparam int CNT_W = 4;

  // md-class operation codes as presented on the op port (6 and 7 are no-ops)
  localparam logic [2:0] MD_MULT  = 3'd0;
  localparam logic [2:0] MD_MULTU = 3'd1;
  localparam logic [2:0] MD_DIV   = 3'd2;
  localparam logic [2:0] MD_DIVU  = 3'd3;
  localparam logic [2:0] MD_MTHI  = 3'd4;
  localparam logic [2:0] MD_MTLO  = 3'd5;

  typedef enum logic [0:0] {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } md_state_e;

endpackage
`default_nettype wire

// File: rtl/md_alu.sv
`default_nettype none
// ============================================================================
//  Module   : md_alu
//  Purpose  : Combinational 64-bit multiply/divide result. For MULT/MULTU
//             {res_hi,res_lo} is the product; for DIV/DIVU res_lo is the
//             quotient and res_hi the remainder. div_zero flags a divide by 0.
//  Revision : 1.0  initial release
// ============================================================================
module md_alu
  import md_pkg::*;
(
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  output logic [31:0] res_hi,
  output logic [31:0] res_lo,
  output logic        div_zero
);

  logic [63:0] prod;

  // Result selection; divide-by-zero yields zeros, the controller ignores them
  always_comb begin
    prod     = '0;
    res_hi   = '0;
    res_lo   = '0;
    div_zero = ((op == MD_DIV) || (op == MD_DIVU)) && (src_b == 32'd0);
    case (op)
      MD_MULT: begin
        // Sign-extend both operands so the low 64 bits are the signed product
        prod   = {{32{src_a[31]}}, src_a} * {{32{src_b[31]}}, src_b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_MULTU: begin
        prod   = {32'd0, src_a} * {32'd0, src_b};
        res_hi = prod[63:32];
        res_lo = prod[31:0];
      end
      MD_DIV: begin
        if (src_b == 32'd0) begin
          res_hi = '0;
          res_lo = '0;
        end else if ((src_a == 32'h8000_0000) && (src_b == 32'hFFFF_FFFF)) begin
          // The only signed quotient that does not fit in 32 bits
          res_lo = 32'h8000_0000;
          res_hi = 32'd0;
        end else begin
          // SystemVerilog signed / and % truncate toward zero, remainder follows dividend
          res_lo = $signed(src_a) / $signed(src_b);
          res_hi = $signed(src_a) % $signed(src_b);
        end
      end
      MD_DIVU: begin
        if (src_b != 32'd0) begin
          res_lo = src_a / src_b;
          res_hi = src_a % src_b;
        end
      end
      default: begin
        res_hi = '0;
        res_lo = '0;
      end
    endcase
  end

endmodule
`default_nettype wire

// File: rtl/md_ctrl.sv
`default_nettype none
// ============================================================================
//  Module   : md_ctrl
//  Purpose  : Sequences the multi-cycle multiply/divide unit, owns HI/LO,
//             and raises the D-stage stall for dependent HI/LO instructions.
//  Options  : MD_CANCEL_EN - adds the cancel port (exception flush abort).
//  Revision : 1.0  initial release
// ============================================================================
module md_ctrl
  import md_pkg::*;
#(
  parameter int MUL_LAT = 5,
  parameter int DIV_LAT = 10
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic [2:0]  op,
  input  logic [31:0] src_a,
  input  logic [31:0] src_b,
  input  logic        use_md_D,
`ifdef MD_CANCEL_EN
  input  logic        cancel,
`endif
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  // Counter load values: count reaches 0 on the last busy cycle
  localparam logic [CNT_W-1:0] MUL_CNT = CNT_W'(MUL_LAT - 1);
  localparam logic [CNT_W-1:0] DIV_CNT = CNT_W'(DIV_LAT - 1);

  md_state_e        state_q, state_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [31:0]      hi_q, hi_d;
  logic [31:0]      lo_q, lo_d;
  logic [31:0]      pend_hi_q, pend_hi_d;
  logic [31:0]      pend_lo_q, pend_lo_d;
  logic             pend_dz_q, pend_dz_d;
  logic             done_q, done_d;

  logic [31:0]      alu_hi;
  logic [31:0]      alu_lo;
  logic             alu_dz;
  logic             cancel_i;

`ifdef MD_CANCEL_EN
  assign cancel_i = cancel;
`else
  assign cancel_i = 1'b0;
`endif

  md_alu u_alu (
    .op       (op),
    .src_a    (src_a),
    .src_b    (src_b),
    .res_hi   (alu_hi),
    .res_lo   (alu_lo),
    .div_zero (alu_dz)
  );

  // Next-state logic: accept in IDLE, count down in RUN, commit at count 0
  always_comb begin
    state_d   = state_q;
    count_d   = count_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    pend_hi_d = pend_hi_q;
    pend_lo_d = pend_lo_q;
    pend_dz_d = pend_dz_q;
    done_d    = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (start && !cancel_i) begin
          case (op)
            MD_MULT, MD_MULTU, MD_DIV, MD_DIVU: begin
              pend_hi_d = alu_hi;
              pend_lo_d = alu_lo;
              pend_dz_d = alu_dz;
              count_d   = ((op == MD_MULT) || (op == MD_MULTU)) ? MUL_CNT : DIV_CNT;
              state_d   = ST_RUN;
            end
            MD_MTHI: hi_d = src_a;
            MD_MTLO: lo_d = src_a;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        if (cancel_i) begin
          // Abort wins over a same-cycle commit
          state_d = ST_IDLE;
        end else if (count_q == '0) begin
          if (!pend_dz_q) begin
            hi_d = pend_hi_q;
            lo_d = pend_lo_q;
          end
          done_d  = 1'b1;
          state_d = ST_IDLE;
        end else begin
          count_d = count_q - 1'b1;
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, counter, pending result and HI/LO registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q   <= ST_IDLE;
      count_q   <= '0;
      hi_q      <= '0;
      lo_q      <= '0;
      pend_hi_q <= '0;
      pend_lo_q <= '0;
      pend_dz_q <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      state_q   <= state_d;
      count_q   <= count_d;
      hi_q      <= hi_d;
      lo_q      <= lo_d;
      pend_hi_q <= pend_hi_d;
      pend_lo_q <= pend_lo_d;
      pend_dz_q <= pend_dz_d;
      done_q    <= done_d;
    end
  end

  assign busy  = (state_q == ST_RUN);
  assign stall = use_md_D & (start | busy);
  assign done  = done_q;
  assign hi    = hi_q;
  assign lo    = lo_q;

endmodule
`default_nettype wire
